// File: rtl/tiny8_mem_arbiter_pkg.sv
// Shared types for the tiny8 memory arbiter: word type, arbiter state and port id.
package tiny8_mem_arbiter_pkg;

   typedef logic [7:0] tiny8_word;
   typedef logic       arb_port_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ACCESS,
      ARB_DONE
   } arb_state_t;

endpackage

// File: rtl/tiny8_rr_select.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that was not served last.
module tiny8_rr_select
   import tiny8_mem_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  arb_port_t  last_i,
   output arb_port_t  grant_o,
   output logic       valid_o
);

   always_comb begin
      valid_o = |req_i;
      grant_o = 1'b0;
      if (&req_i) begin
         grant_o = ~last_i;
      end else if (req_i[1]) begin
         grant_o = 1'b1;
      end
   end

endmodule

// File: rtl/tiny8_mem_arbiter.sv
// Shares one tiny8 memory port between fetch (p0) and load/store (p1); one access in flight,
// round-robin on ties, memory-side signals come from registered copies so port inputs may move.
module tiny8_mem_arbiter
   import tiny8_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT    = 15,
   parameter int RESET_PRIO = 0
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      p0_read,
   input  logic      p0_write,
   input  tiny8_word p0_address,
   input  tiny8_word p0_wdata,
   output logic      p0_resp,
   output tiny8_word p0_rdata,
   input  logic      p1_read,
   input  logic      p1_write,
   input  tiny8_word p1_address,
   input  tiny8_word p1_wdata,
   output logic      p1_resp,
   output tiny8_word p1_rdata,
   output logic      mem_read,
   output logic      mem_write,
   output tiny8_word mem_address,
   output tiny8_word mem_wdata,
   input  logic      mem_resp,
   input  tiny8_word mem_rdata,
   output logic      timeout_err
);

   localparam int        TW       = $clog2(TIMEOUT + 1);
   localparam arb_port_t LAST_RST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

   arb_state_t    state_q, state_d;
   arb_port_t     grant_q, grant_d;
   arb_port_t     last_q, last_d;
   logic          wr_q, wr_d;
   tiny8_word     addr_q, addr_d;
   tiny8_word     wdata_q, wdata_d;
   tiny8_word     rdata_q, rdata_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          terr_q, terr_d;

   logic [1:0]    req;
   arb_port_t     sel_grant;
   logic          sel_valid;

   assign req = {p1_read | p1_write, p0_read | p0_write};

   tiny8_rr_select u_rr_select (
      .req_i   (req),
      .last_i  (last_q),
      .grant_o (sel_grant),
      .valid_o (sel_valid)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      timer_d = timer_q;
      terr_d  = terr_q;
      case (state_q)
         ARB_IDLE: begin
            if (sel_valid) begin
               grant_d = sel_grant;
               // Write wins when a master raises read and write together.
               wr_d    = sel_grant ? p1_write   : p0_write;
               addr_d  = sel_grant ? p1_address : p0_address;
               wdata_d = sel_grant ? p1_wdata   : p0_wdata;
               timer_d = '0;
               state_d = ARB_ACCESS;
            end
         end
         ARB_ACCESS: begin
            if (mem_resp) begin
               rdata_d = wr_q ? '0 : mem_rdata;
               state_d = ARB_DONE;
            end else if (timer_q == TW'(TIMEOUT)) begin
               rdata_d = '0;
               terr_d  = 1'b1;
               state_d = ARB_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ARB_DONE: begin
            last_d  = grant_q;
            state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         grant_q <= 1'b0;
         last_q  <= LAST_RST;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         timer_q <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         timer_q <= timer_d;
         terr_q  <= terr_d;
      end
   end

   assign mem_read    = (state_q == ARB_ACCESS) && !wr_q;
   assign mem_write   = (state_q == ARB_ACCESS) &&  wr_q;
   assign mem_address = (state_q == ARB_ACCESS) ? addr_q  : '0;
   assign mem_wdata   = (state_q == ARB_ACCESS) ? wdata_q : '0;

   assign p0_resp     = (state_q == ARB_DONE) && (grant_q == 1'b0);
   assign p1_resp     = (state_q == ARB_DONE) && (grant_q == 1'b1);
   assign p0_rdata    = p0_resp ? rdata_q : '0;
   assign p1_rdata    = p1_resp ? rdata_q : '0;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_tiny8_mem_arbiter.sv
// Directed bench for tiny8_mem_arbiter with a behavioural memory that can stall or never answer.
module tb_tiny8_mem_arbiter;
   import tiny8_mem_arbiter_pkg::*;

   localparam int TIMEOUT = 15;

   logic      clk = 1'b0;
   logic      rst_n = 1'b0;
   logic      p0_read = 1'b0, p0_write = 1'b0;
   tiny8_word p0_address = '0, p0_wdata = '0;
   logic      p1_read = 1'b0, p1_write = 1'b0;
   tiny8_word p1_address = '0, p1_wdata = '0;
   logic      p0_resp, p1_resp;
   tiny8_word p0_rdata, p1_rdata;
   logic      mem_read, mem_write, mem_resp, timeout_err;
   tiny8_word mem_address, mem_wdata, mem_rdata;

   tiny8_word mem [256];
   logic      mem_en = 1'b1;
   int        wait_cfg = 0;
   int        wait_cnt = 0;

   int        checks = 0;
   int        failures = 0;
   int        ord [4];
   tiny8_word rdv [4];

   always #5 clk = ~clk;

   tiny8_mem_arbiter #(.TIMEOUT(TIMEOUT), .RESET_PRIO(0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .p0_read     (p0_read),
      .p0_write    (p0_write),
      .p0_address  (p0_address),
      .p0_wdata    (p0_wdata),
      .p0_resp     (p0_resp),
      .p0_rdata    (p0_rdata),
      .p1_read     (p1_read),
      .p1_write    (p1_write),
      .p1_address  (p1_address),
      .p1_wdata    (p1_wdata),
      .p1_resp     (p1_resp),
      .p1_rdata    (p1_rdata),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_resp    (mem_resp),
      .mem_rdata   (mem_rdata),
      .timeout_err (timeout_err)
   );

   // Memory answers combinationally once wait_cfg stall cycles have elapsed.
   assign mem_resp  = mem_en && (mem_read || mem_write) && (wait_cnt >= wait_cfg);
   assign mem_rdata = mem[mem_address];

   always @(posedge clk) begin
      if (mem_write && mem_resp) mem[mem_address] = mem_wdata;
   end

   always @(posedge clk) begin
      if ((mem_read || mem_write) && !mem_resp) wait_cnt <= wait_cnt + 1;
      else                                      wait_cnt <= 0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drop_all();
      p0_read = 1'b0; p0_write = 1'b0;
      p1_read = 1'b0; p1_write = 1'b0;
   endtask

   // Issues one access from a single port (called at a falling edge with the arbiter idle),
   // returns latency in cycles from the granting edge and what the memory side showed.
   task automatic run_access(input int port, input logic rd, input logic wr,
                             input tiny8_word addr, input tiny8_word wd,
                             output int lat, output tiny8_word rdat,
                             output logic saw_rd, output logic saw_wr,
                             output logic saw_other, output logic saw_both);
      lat = -1; rdat = '0;
      saw_rd = 1'b0; saw_wr = 1'b0; saw_other = 1'b0; saw_both = 1'b0;
      if (port == 0) begin
         p0_read = rd; p0_write = wr; p0_address = addr; p0_wdata = wd;
      end else begin
         p1_read = rd; p1_write = wr; p1_address = addr; p1_wdata = wd;
      end
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         saw_rd   |= mem_read;
         saw_wr   |= mem_write;
         saw_both |= mem_read & mem_write;
         if ((port == 0) ? p1_resp : p0_resp) saw_other = 1'b1;
         if ((port == 0) ? p0_resp : p1_resp) begin
            lat  = c;
            rdat = (port == 0) ? p0_rdata : p1_rdata;
            break;
         end
      end
      drop_all();
      @(negedge clk);
      chk("resp_one_cycle", {30'd0, p0_resp, p1_resp}, 32'd0);
      chk("rdata_cleared", {16'd0, p0_rdata, p1_rdata}, 32'd0);
   endtask

   // Holds p0 (addr 3) and p1 (addr 4) reads and records which port each response went to.
   task automatic run_both(input int n, output int got);
      got = 0;
      p0_read = 1'b1; p0_address = 8'h03;
      p1_read = 1'b1; p1_address = 8'h04;
      for (int c = 0; c < 80 && got < n; c++) begin
         @(negedge clk);
         if (p0_resp && p1_resp) begin
            ord[got] = 2; rdv[got] = '0; got++;
         end else if (p0_resp) begin
            ord[got] = 0; rdv[got] = p0_rdata; got++;
         end else if (p1_resp) begin
            ord[got] = 1; rdv[got] = p1_rdata; got++;
         end
      end
      drop_all();
      @(negedge clk);
   endtask

   initial begin
      int        lat, got;
      tiny8_word rdat;
      logic      s_rd, s_wr, s_oth, s_both;

      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[3] = 8'hA5;
      mem[4] = 8'h4B;

      repeat (3) @(negedge clk);
      chk("rst_p0_resp", {31'd0, p0_resp}, 32'd0);
      chk("rst_p1_resp", {31'd0, p1_resp}, 32'd0);
      chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rst_mem_addr", {24'd0, mem_address}, 32'd0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Simultaneous requests after reset: p0 first, then strict alternation.
      run_both(4, got);
      chk("both_count", got, 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("both_order", ord[i], (i % 2 == 0) ? 32'd0 : 32'd1);
         chk("both_rdata", {24'd0, rdv[i]}, (i % 2 == 0) ? 32'hA5 : 32'h4B);
      end

      run_access(0, 1'b1, 1'b0, 8'h03, 8'h00, lat, rdat, s_rd, s_wr, s_oth, s_both);
      chk("p0_read_lat", lat, 32'd2);
      chk("p0_read_data", {24'd0, rdat}, 32'hA5);
      chk("p0_read_memrd", {30'd0, s_rd, s_wr}, 32'b10);

      run_access(1, 1'b0, 1'b1, 8'h06, 8'h5C, lat, rdat, s_rd, s_wr, s_oth, s_both);
      chk("p1_write_lat", lat, 32'd2);
      chk("p1_write_memwr", {30'd0, s_rd, s_wr}, 32'b01);
      chk("p1_write_no_p0", {31'd0, s_oth}, 32'd0);
      chk("p1_write_rdata", {24'd0, rdat}, 32'h00);
      run_access(0, 1'b1, 1'b0, 8'h06, 8'h00, lat, rdat, s_rd, s_wr, s_oth, s_both);
      chk("p0_readback_5c", {24'd0, rdat}, 32'h5C);

      run_access(0, 1'b1, 1'b1, 8'h08, 8'h77, lat, rdat, s_rd, s_wr, s_oth, s_both);
      chk("rw_write_only", {30'd0, s_rd, s_wr}, 32'b01);
      chk("rw_never_both", {31'd0, s_both}, 32'd0);
      run_access(1, 1'b1, 1'b0, 8'h08, 8'h00, lat, rdat, s_rd, s_wr, s_oth, s_both);
      chk("rw_readback", {24'd0, rdat}, 32'h77);

      wait_cfg = 2;
      run_access(1, 1'b1, 1'b0, 8'h03, 8'h00, lat, rdat, s_rd, s_wr, s_oth, s_both);
      chk("wait2_lat", lat, 32'd4);
      chk("wait2_data", {24'd0, rdat}, 32'hA5);
      wait_cfg = 0;

      chk("terr_before", {31'd0, timeout_err}, 32'd0);
      mem_en = 1'b0;
      run_access(0, 1'b1, 1'b0, 8'h03, 8'h00, lat, rdat, s_rd, s_wr, s_oth, s_both);
      chk("timeout_lat", lat, TIMEOUT + 2);
      chk("timeout_rdata", {24'd0, rdat}, 32'h00);
      chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
      mem_en = 1'b1;
      run_access(1, 1'b1, 1'b0, 8'h04, 8'h00, lat, rdat, s_rd, s_wr, s_oth, s_both);
      chk("after_to_lat", lat, 32'd2);
      chk("after_to_data", {24'd0, rdat}, 32'h4B);
      chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

      // Leave last_grant at p0 so a tie would favour p1 unless reset restores priority.
      run_access(0, 1'b1, 1'b0, 8'h04, 8'h00, lat, rdat, s_rd, s_wr, s_oth, s_both);
      chk("pre_reset_data", {24'd0, rdat}, 32'h4B);

      wait_cfg = 3;
      p1_write = 1'b1; p1_address = 8'h09; p1_wdata = 8'h11;
      @(negedge clk);
      chk("abort_memwr_on", {31'd0, mem_write}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_memwr_off", {31'd0, mem_write}, 32'd0);
      chk("abort_memaddr", {24'd0, mem_address}, 32'd0);
      drop_all();
      wait_cfg = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("abort_no_p1_resp", {31'd0, p1_resp}, 32'd0);
      end
      rst_n = 1'b1;
      chk("abort_terr_clr", {31'd0, timeout_err}, 32'd0);
      chk("abort_no_write", {24'd0, mem[9]}, 32'd0);
      run_both(2, got);
      chk("post_rst_count", got, 32'd2);
      chk("post_rst_first", ord[0], 32'd0);
      chk("post_rst_second", ord[1], 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
